register_slice_sync_rst: RTL and testbench



---
 rtl/svlib_pkg.sv | 21 ++
 rtl/register_en_sync_rst.sv | 33 +++
 rtl/register_slice_sync_rst.sv | 125 ++++++++++++
 tb/tb_register_slice_sync_rst.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/svlib_pkg.sv
`default_nettype none
// ============================================================================
// Module   : svlib_pkg
// Purpose  : Shared types for the streaming-primitive library.
//            reg_slice_state_e encodes the register-slice fill level; the
//            numeric code of each state equals the number of held entries,
//            so the state register drives the occupancy output directly.
// Revision : 1.0 - initial release
// ============================================================================
package svlib_pkg;

    localparam int unsigned RS_STATE_W = 2;

    typedef enum logic [RS_STATE_W-1:0] {
        RS_EMPTY = 2'd0,
        RS_BUSY  = 2'd1,
        RS_FULL  = 2'd2
    } reg_slice_state_e;

endpackage : svlib_pkg
`default_nettype wire

// File: rtl/register_en_sync_rst.sv
`default_nettype none
// ============================================================================
// Module   : register_en_sync_rst
// Purpose  : WIDTH-bit register with load enable and synchronous
//            active-high reset to RESET_VAL.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            en   - load enable; din is captured when high
//            din  - WIDTH-bit data in
//            dout - WIDTH-bit registered data out
// Revision : 1.0 - initial release
// ============================================================================
module register_en_sync_rst #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (en) begin
            dout <= din;
        end
    end

endmodule : register_en_sync_rst
`default_nettype wire

// File: rtl/register_slice_sync_rst.sv
`default_nettype none
// ============================================================================
// Module   : register_slice_sync_rst
// Purpose  : Full-throughput valid/ready pipeline register built as a
//            two-entry skid buffer. All outputs come from registers (in_ready
//            additionally gated by rst), so no combinational path crosses the
//            slice in either direction.
// Ports    : clk       - rising-edge clock
//            rst       - synchronous active-high reset
//            in_valid  - upstream beat valid
//            in_ready  - slice can accept a beat
//            in_data   - upstream payload (WIDTH bits)
//            out_valid - slice presents a beat
//            out_ready - downstream accepts
//            out_data  - payload, straight from the main register
//            occupancy - number of held beats (0, 1 or 2)
// Revision : 1.0 - initial release
// ============================================================================
module register_slice_sync_rst
    import svlib_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    reg_slice_state_e r_state;
    reg_slice_state_e w_state_next;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_load_main;
    logic             w_load_skid;
    logic [WIDTH-1:0] w_main_din;
    logic [WIDTH-1:0] r_skid;

    assign out_valid  = (r_state != RS_EMPTY);
    assign in_ready   = (r_state != RS_FULL) & ~rst;
    assign occupancy  = r_state;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // When FULL the skid entry is the older one and refills main; otherwise
    // main only ever loads fresh upstream data.
    assign w_main_din = (r_state == RS_FULL) ? r_skid : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RS_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_main  = 1'b0;
        w_load_skid  = 1'b0;
        case (r_state)
            RS_EMPTY: begin
                if (w_in_xfer) begin
                    w_load_main  = 1'b1;
                    w_state_next = RS_BUSY;
                end
            end
            RS_BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    // Pass-through: the departing beat is replaced in place.
                    w_load_main = 1'b1;
                end else if (w_in_xfer) begin
                    // Downstream stalled: park the new beat behind main.
                    w_load_skid  = 1'b1;
                    w_state_next = RS_FULL;
                end else if (w_out_xfer) begin
                    // Main keeps its stale contents; out_valid marks it empty.
                    w_state_next = RS_EMPTY;
                end
            end
            RS_FULL: begin
                if (w_out_xfer) begin
                    w_load_main  = 1'b1;
                    w_state_next = RS_BUSY;
                end
            end
            default: begin
                // Unused fourth code: fall back to a clean empty slice.
                w_state_next = RS_EMPTY;
            end
        endcase
    end

    register_en_sync_rst #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .en   (w_load_main),
        .din  (w_main_din),
        .dout (out_data)
    );

    register_en_sync_rst #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .en   (w_load_skid),
        .din  (in_data),
        .dout (r_skid)
    );

endmodule : register_slice_sync_rst
`default_nettype wire

// File: tb/tb_register_slice_sync_rst.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_register_slice_sync_rst
// Purpose  : Self-checking bench for register_slice_sync_rst. The reference
//            model is a plain FIFO queue with capacity two: a beat enters when
//            in_valid is high and fewer than two are held, the front leaves
//            when out_ready is high and something is held, reset empties it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_slice_sync_rst;

    localparam int         WIDTH   = 8;
    localparam logic [7:0] RST_VAL = 8'h00;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data   = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    register_slice_sync_rst #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int         checks      = 0;
    int         failures    = 0;
    bit         armed       = 1'b0;
    bit         fresh_reset = 1'b0;
    logic [7:0] model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare the DUT against the model, then advance
    // the model by the transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        int sz;
        sz = model_q.size();
        if (armed) begin
            check("occupancy", 32'(occupancy), 32'(sz));
            check("out_valid", 32'(out_valid), 32'(sz != 0));
            check("in_ready", 32'(in_ready), 32'((sz < 2) && !rst));
            if (sz != 0) begin
                check("out_data", 32'(out_data), 32'(model_q[0]));
            end else if (fresh_reset) begin
                check("out_data_reset", 32'(out_data), 32'(RST_VAL));
            end
        end
        if (rst) begin
            model_q.delete();
            fresh_reset = 1'b1;
        end else begin
            if (out_ready && sz != 0) begin
                void'(model_q.pop_front());
            end
            if (in_valid && sz < 2) begin
                model_q.push_back(in_data);
                fresh_reset = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until the slice accepts it (bounded).
    task automatic send(input logic [7:0] d, input logic ordy);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = ordy;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            n++;
            if (!acc && n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: beat %0h not accepted after %0d cycles, required acceptance", d, n);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        in_valid  = 1'b0;
        out_ready = ordy;
        repeat (n) cyc();
    endtask

    initial begin
        // Reset held for three edges with a beat offered upstream.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        @(posedge clk);
        armed = 1'b1;
        #1;
        repeat (2) cyc();
        rst = 1'b0;
        send(8'hAA, 1'b0);
        idle(1, 1'b0);
        idle(3, 1'b1);

        // Back-to-back streaming with the sink always ready.
        for (int i = 1; i <= 16; i++) begin
            send(8'(i), 1'b1);
        end
        idle(3, 1'b1);

        // Backpressure: third beat must be held upstream until the sink drains.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'h33;
        out_ready = 1'b0;
        repeat (3) cyc();
        send(8'h33, 1'b1);
        idle(5, 1'b1);

        // Simultaneous in/out while one beat is held.
        send(8'h40, 1'b0);
        send(8'h41, 1'b1);
        idle(3, 1'b1);

        // Reset while full discards both held beats.
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        cyc();
        rst = 1'b0;
        idle(5, 1'b1);

        // Randomized traffic with varying valid/ready densities.
        for (int i = 0; i < 10000; i++) begin
            int vp;
            int rp;
            vp = ((i / 1000) % 2 == 0) ? 70 : 40;
            rp = ((i / 500) % 3 == 0) ? 30 : 75;
            in_valid  = ($urandom_range(0, 99) < vp);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 99) < rp);
            rst       = ($urandom_range(0, 999) == 0);
            cyc();
        end
        rst = 1'b0;
        idle(10, 1'b1);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_slice_sync_rst
`default_nettype wire
